// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, issues instruction-memory reads and drives the
// write side of the IF/ID latch (instruction, PC+4, latch enable, flush).
module ifetch_unit #(
  parameter logic [31:0] PC_INIT  = 32'h0000_0000,
  parameter int          PC_WIDTH = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                ihit,
  input  logic [31:0]         imemload,
  output logic                iREN,
  output logic [PC_WIDTH-1:0] imemaddr,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_target,
  input  logic                halt,
  output logic [31:0]         instr_out,
  output logic [PC_WIDTH-1:0] pcp4_out,
  output logic                fetch_valid,
  output logic                flush_out
);

  typedef enum logic [1:0] {
    FETCH,
    REDIR_WAIT,
    HALTED
  } state_t;

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);
  // The PC is kept word aligned, so the reset value is aligned as well.
  localparam logic [PC_WIDTH-1:0] PC_RESET   = PC_WIDTH'(PC_INIT) & ALIGN_MASK;

  state_t              state, state_n;
  logic [PC_WIDTH-1:0] pc, pc_n;
  logic [PC_WIDTH-1:0] pend_pc, pend_pc_n;
  logic [PC_WIDTH-1:0] target_aligned;

  assign target_aligned = redirect_target & ALIGN_MASK;
  assign imemaddr       = pc;
  assign instr_out      = imemload;
  assign pcp4_out       = pc + PC_WIDTH'(4);
  assign flush_out      = redirect_valid && (state != HALTED);

  // State, PC and pending-redirect registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of block order.
    if (!nRST) begin
      state   <= FETCH;
      pc      <= PC_RESET;
      pend_pc <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pend_pc <= pend_pc_n;
    end
  end

  // Next-state, next-PC and handshake outputs; halt beats redirect beats hit.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_n     = state;
    pc_n        = pc;
    pend_pc_n   = pend_pc;
    iREN        = 1'b1;
    fetch_valid = 1'b0;

    unique case (state)
      FETCH: begin
        if (halt) begin
          state_n = HALTED;
        end else if (redirect_valid) begin
          if (ihit) begin
            // Returned word belongs to the wrong path; drop it and jump now.
            pc_n = target_aligned;
          end else begin
            // A read at the old pc is still in flight; wait for it to land.
            pend_pc_n = target_aligned;
            state_n   = REDIR_WAIT;
          end
        end else if (ihit && !stall) begin
          fetch_valid = 1'b1;
          pc_n        = pc + PC_WIDTH'(4);
        end
      end

      REDIR_WAIT: begin
        if (redirect_valid) begin
          pend_pc_n = target_aligned;
        end
        if (halt) begin
          state_n = HALTED;
        end else if (ihit) begin
          pc_n    = redirect_valid ? target_aligned : pend_pc;
          state_n = FETCH;
        end
      end

      HALTED: begin
        iREN = 1'b0;
      end

      default: begin
        state_n = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: per-cycle output checks plus a scoreboard
// that queues the expected IF/ID payload of every cycle that should latch.
module tb_ifetch_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;

  logic        iren0, iren1;
  logic [31:0] addr0, addr1, instr0, instr1, pcp40, pcp41;
  logic        fv0, fv1, fl0, fl1;

  // Selects which instance the checks observe.
  logic        sel;
  logic        mon_iren, mon_fv, mon_fl;
  logic [31:0] mon_addr, mon_instr, mon_pcp4;

  int errors = 0;
  int checks = 0;

  // Expected {pcp4_out, instr_out} for each accepted fetch.
  logic [63:0] sb[$];

  always #5 CLK = ~CLK;

  ifetch_unit #(.PC_INIT(32'h0000_0000), .PC_WIDTH(32)) dut0 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .iREN(iren0), .imemaddr(addr0), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt(halt), .instr_out(instr0), .pcp4_out(pcp40),
    .fetch_valid(fv0), .flush_out(fl0)
  );

  ifetch_unit #(.PC_INIT(32'hFFFF_FFF8), .PC_WIDTH(32)) dut1 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .iREN(iren1), .imemaddr(addr1), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt(halt), .instr_out(instr1), .pcp4_out(pcp41),
    .fetch_valid(fv1), .flush_out(fl1)
  );

  assign mon_iren  = sel ? iren1  : iren0;
  assign mon_addr  = sel ? addr1  : addr0;
  assign mon_instr = sel ? instr1 : instr0;
  assign mon_pcp4  = sel ? pcp41  : pcp40;
  assign mon_fv    = sel ? fv1    : fv0;
  assign mon_fl    = sel ? fl1    : fl0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Synchronous reset pulse of one cycle with all inputs idle.
  task automatic do_reset();
    nRST = 1'b0; ihit = 1'b0; stall = 1'b0; halt = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0; imemload = '0;
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  // One cycle: drive inputs, check outputs mid-cycle, advance to next edge.
  task automatic step(input string tag, input logic rv, input logic [31:0] tgt,
                      input logic h, input logic ih, input logic st,
                      input logic [31:0] exp_addr, input logic exp_iren,
                      input logic exp_fv, input logic exp_fl);
    logic [63:0] item;
    redirect_valid  = rv;
    redirect_target = tgt;
    halt            = h;
    ihit            = ih;
    stall           = st;
    imemload        = $urandom;
    #2;
    check({tag, ".addr"},  mon_addr,  exp_addr);
    check({tag, ".iren"},  32'(mon_iren), 32'(exp_iren));
    check({tag, ".fv"},    32'(mon_fv),   32'(exp_fv));
    check({tag, ".flush"}, 32'(mon_fl),   32'(exp_fl));
    check({tag, ".instr"}, mon_instr, imemload);
    if (exp_fv) sb.push_back({exp_addr + 32'd4, imemload});
    if (mon_fv === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL %s.sb_underflow observed=fetch expected=none", tag);
      end
      if (sb.size() > 0) begin
        item = sb.pop_front();
        check({tag, ".sb_pcp4"},  mon_pcp4,  item[63:32]);
        check({tag, ".sb_instr"}, mon_instr, item[31:0]);
      end
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0;
    do_reset();
    // Reset state, no hit yet.
    step("rst",    0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
    // Sequential fetch with ihit held high.
    step("seq0",   0, 0, 0, 1, 0, 32'h0,  1, 1, 0);
    step("seq4",   0, 0, 0, 1, 0, 32'h4,  1, 1, 0);
    step("seq8",   0, 0, 0, 1, 0, 32'h8,  1, 1, 0);
    step("seqC",   0, 0, 0, 1, 0, 32'hC,  1, 1, 0);
    // Stall for three cycles at 0x10.
    step("stl1",   0, 0, 0, 1, 1, 32'h10, 1, 0, 0);
    step("stl2",   0, 0, 0, 1, 1, 32'h10, 1, 0, 0);
    step("stl3",   0, 0, 0, 1, 1, 32'h10, 1, 0, 0);
    step("stl_go", 0, 0, 0, 1, 0, 32'h10, 1, 1, 0);
    step("seq14",  0, 0, 0, 1, 0, 32'h14, 1, 1, 0);
    step("seq18",  0, 0, 0, 1, 0, 32'h18, 1, 1, 0);
    step("seq1C",  0, 0, 0, 1, 0, 32'h1C, 1, 1, 0);
    // Redirect on a hit: word dropped, unaligned target aligned.
    step("rdh",    1, 32'h103, 0, 1, 0, 32'h20, 1, 0, 1);
    step("rdh_to", 1, 32'h40,  0, 1, 0, 32'h100, 1, 0, 1);
    // Redirect on a miss, overwritten two cycles later, then the hit lands.
    step("rdm1",   1, 32'h200, 0, 0, 0, 32'h40, 1, 0, 1);
    step("rdm2",   0, 0,       0, 0, 0, 32'h40, 1, 0, 0);
    step("rdm3",   1, 32'h300, 0, 0, 0, 32'h40, 1, 0, 1);
    step("rdm4",   0, 0,       0, 0, 0, 32'h40, 1, 0, 0);
    step("rdm5",   0, 0,       0, 1, 0, 32'h40, 1, 0, 0);
    step("rdm_to", 0, 0,       0, 1, 0, 32'h300, 1, 1, 0);
    // Halt from FETCH; later hits and redirects are ignored.
    step("hf",     0, 0,       1, 1, 0, 32'h304, 1, 0, 0);
    step("hf1",    1, 32'h500, 0, 1, 0, 32'h304, 0, 0, 0);
    step("hf2",    0, 0,       0, 1, 0, 32'h304, 0, 0, 0);
    do_reset();
    step("hf_rst", 0, 0,       0, 0, 0, 32'h0, 1, 0, 0);
    // Halt from REDIR_WAIT.
    step("hw0",    1, 32'h80,  0, 0, 0, 32'h0, 1, 0, 1);
    step("hw1",    0, 0,       1, 1, 0, 32'h0, 1, 0, 0);
    step("hw2",    1, 32'h90,  0, 1, 0, 32'h0, 0, 0, 0);
    step("hw3",    0, 0,       0, 1, 0, 32'h0, 0, 0, 0);

    // Wrap-around instance.
    sel = 1'b1;
    do_reset();
    step("wr0",    0, 0, 0, 1, 0, 32'hFFFF_FFF8, 1, 1, 0);
    #2;
    check("wr_pcp4_zero", pcp41 + 32'd0, 32'h0);
    // Re-align to the cycle: pc now FFFF_FFFC (check above sampled pcp4 at it).
    #(-0);
    step("wr1",    0, 0, 0, 1, 0, 32'hFFFF_FFFC, 1, 1, 0);
    step("wr2",    0, 0, 0, 1, 0, 32'h0000_0000, 1, 1, 0);
    step("wrmiss", 0, 0, 0, 0, 0, 32'h0000_0004, 1, 0, 0);
    // Reset in the middle of a miss.
    do_reset();
    step("wr_rst", 0, 0, 0, 0, 0, 32'hFFFF_FFF8, 1, 0, 0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
